// File: rtl/hkspi_master.sv
// hkspi_master: SPI initiator issuing housekeeping-SPI stream read/write commands.
// Mode 0, MSB first: command byte, register address, then 1..256 data bytes per transaction.
module hkspi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       spi_csb,
  output logic       spi_sck,
  output logic       spi_sdi,
  input  logic       spi_sdo
);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ  = 8'h40;

  state_t     state_r;
  logic [7:0] div_cnt_r;
  logic [2:0] bit_cnt_r;
  logic [8:0] byte_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] addr_r;
  logic [7:0] len_r;
  logic       rw_r;

  logic       div_done_s;
  logic       last_byte_s;
  logic       is_data_s;
  logic       next_wdata_s;
  logic       load_go_s;
  logic [7:0] load_byte_s;

  // Byte-boundary decode and the value to shift out for the current byte.
  always_comb begin
    div_done_s   = (div_cnt_r == DIV_LAST);
    last_byte_s  = (byte_cnt_r == ({1'b0, len_r} + 9'd2));
    is_data_s    = (byte_cnt_r >= 9'd2);
    next_wdata_s = rw_r && (byte_cnt_r >= 9'd1);
    load_go_s    = !(is_data_s && rw_r) || (wr_valid && wr_ready);
    if (byte_cnt_r == 9'd0) begin
      load_byte_s = rw_r ? CMD_WRITE : CMD_READ;
    end else if (byte_cnt_r == 9'd1) begin
      load_byte_s = addr_r;
    end else if (rw_r) begin
      load_byte_s = wr_data;
    end else begin
      load_byte_s = 8'h00;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 9'd0;
      shift_r    <= 8'h00;
      addr_r     <= 8'h00;
      len_r      <= 8'h00;
      rw_r       <= 1'b0;
      wr_ready   <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      spi_csb    <= 1'b1;
      spi_sck    <= 1'b0;
      spi_sdi    <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            rw_r       <= rw;
            addr_r     <= addr;
            len_r      <= len;
            busy       <= 1'b1;
            spi_csb    <= 1'b0;
            div_cnt_r  <= 8'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 9'd0;
            state_r    <= SETUP;
          end
        end
        SETUP: begin
          if (div_done_s) begin
            div_cnt_r <= 8'd0;
            state_r   <= LOAD;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        LOAD: begin
          // Write data bytes wait here with SCK low until the byte is handed over.
          if (load_go_s) begin
            shift_r   <= load_byte_s;
            spi_sdi   <= load_byte_s[7];
            wr_ready  <= 1'b0;
            bit_cnt_r <= 3'd0;
            div_cnt_r <= 8'd0;
            state_r   <= LOW;
          end
        end
        LOW: begin
          if (div_done_s) begin
            spi_sck   <= 1'b1;
            shift_r   <= {shift_r[6:0], spi_sdo};
            div_cnt_r <= 8'd0;
            state_r   <= HIGH;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        HIGH: begin
          if (div_done_s) begin
            spi_sck   <= 1'b0;
            div_cnt_r <= 8'd0;
            if (bit_cnt_r == 3'd7) begin
              if (is_data_s && !rw_r) begin
                rd_data  <= shift_r;
                rd_valid <= 1'b1;
              end
              if (last_byte_s) begin
                spi_sdi <= 1'b0;
                state_r <= HOLD;
              end else begin
                byte_cnt_r <= byte_cnt_r + 9'd1;
                wr_ready   <= next_wdata_s;
                state_r    <= LOAD;
              end
            end else begin
              // shift_r was advanced on the rising edge, so bit 7 is the next bit out.
              bit_cnt_r <= bit_cnt_r + 3'd1;
              spi_sdi   <= shift_r[7];
              state_r   <= LOW;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        HOLD: begin
          if (div_done_s) begin
            spi_csb   <= 1'b1;
            done      <= 1'b1;
            div_cnt_r <= 8'd0;
            state_r   <= GAP;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        GAP: begin
          if (div_done_s) begin
            busy      <= 1'b0;
            div_cnt_r <= 8'd0;
            state_r   <= IDLE;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hkspi_master.sv
// Self-checking bench for hkspi_master: scoreboard of SDI bytes and read bytes against a
// housekeeping responder model, plus timing checks at CLK_DIV=4 and CLK_DIV=1.
module tb_hkspi_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, rw, wr_valid, wr_ready, rd_valid, busy, done;
  logic [7:0] addr, len, wr_data, rd_data;
  logic       spi_csb, spi_sck, spi_sdi, spi_sdo;

  logic       start1, rw1, wr_valid1, wr_ready1, rd_valid1, busy1, done1;
  logic [7:0] addr1, len1, wr_data1, rd_data1;
  logic       csb1, sck1, sdi1, sdo1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_sdi_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] resp_regs [256];
  logic [7:0] resp_addr;
  logic [7:0] mon_shift;
  int         mon_bits = 0;
  int         rise_cnt = 0;
  int         done_cnt = 0;
  int         rd_cnt = 0;
  int         csb_low_cnt = 0;
  logic       sck_prev = 1'b0;

  hkspi_master #(.CLK_DIV(4)) dut (
    .clock(clock), .reset(reset), .start(start), .rw(rw), .addr(addr), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .spi_csb(spi_csb), .spi_sck(spi_sck),
    .spi_sdi(spi_sdi), .spi_sdo(spi_sdo)
  );

  hkspi_master #(.CLK_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .rw(rw1), .addr(addr1), .len(len1),
    .wr_data(wr_data1), .wr_valid(wr_valid1), .wr_ready(wr_ready1), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .busy(busy1), .done(done1), .spi_csb(csb1), .spi_sck(sck1),
    .spi_sdi(sdi1), .spi_sdo(sdo1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Responder model and SDI byte scoreboard for the CLK_DIV=4 instance.
  always @(negedge clock) begin
    logic [7:0] e, tmp, ra;
    int idx;
    if (!spi_csb) csb_low_cnt++;
    if (done) done_cnt++;
    if (rd_valid) begin
      rd_cnt++;
      total++;
      if (exp_rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%02h", rd_data);
      end else begin
        e = exp_rd_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data got=%02h exp=%02h", rd_data, e);
        end
      end
    end
    if (spi_csb) begin
      mon_bits = 0;
    end else begin
      if (spi_sck && !sck_prev) begin
        mon_shift = {mon_shift[6:0], spi_sdi};
        mon_bits++;
        rise_cnt++;
        if (mon_bits % 8 == 0) begin
          if (mon_bits == 16) resp_addr = mon_shift;
          total++;
          if (exp_sdi_q.size() == 0) begin
            bad++;
            $display("FAIL sdi_unexpected got=%02h", mon_shift);
          end else begin
            e = exp_sdi_q.pop_front();
            if (mon_shift !== e) begin
              bad++;
              $display("FAIL sdi_byte got=%02h exp=%02h", mon_shift, e);
            end
          end
        end
      end
      if (!spi_sck && sck_prev) begin
        idx = mon_bits / 8;
        if (idx >= 2) begin
          ra = resp_addr + 8'(idx - 2);
          tmp = resp_regs[ra];
          spi_sdo = tmp[3'(7 - (mon_bits % 8))];
        end else begin
          spi_sdo = 1'b0;
        end
      end
    end
    sck_prev = spi_sck;
  end

  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] l,
                         output bit timed_out);
    int n;
    @(negedge clock);
    rw = r; addr = a; len = l; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clock);
      n++;
    end
    timed_out = (n >= 20000);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || spi_sdi !== 1'b0) begin
      bad++;
      $display("FAIL reset_spi got=%b%b%b exp=100", spi_csb, spi_sck, spi_sdi);
    end
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b%b%b%b exp=0000", busy, done, wr_ready, rd_valid);
    end
    total++;
    if (rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_data got=%02h exp=00", rd_data);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_write_single;
    bit to;
    int r0, d0;
    r0 = rise_cnt; d0 = done_cnt;
    exp_sdi_q.push_back(8'h80); exp_sdi_q.push_back(8'h0b); exp_sdi_q.push_back(8'h01);
    wr_data = 8'h01; wr_valid = 1'b1;
    csb_low_cnt = 0;
    run_txn(1'b1, 8'h0b, 8'h00, to);
    wr_valid = 1'b0;
    total++;
    if (to) begin bad++; $display("FAIL wr1_timeout got=busy exp=idle"); end
    total++;
    if (rise_cnt - r0 != 24) begin
      bad++;
      $display("FAIL wr1_sck_rises got=%0d exp=24", rise_cnt - r0);
    end
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL wr1_done got=%0d exp=1", done_cnt - d0); end
    total++;
    if (csb_low_cnt != 2 * 4 + 3 * (1 + 16 * 4)) begin
      bad++;
      $display("FAIL wr1_csb_low got=%0d exp=%0d", csb_low_cnt, 2 * 4 + 3 * (1 + 16 * 4));
    end
    total++;
    if (exp_sdi_q.size() != 0) begin
      bad++;
      $display("FAIL wr1_missing_bytes got=%0d exp=0", exp_sdi_q.size());
      exp_sdi_q.delete();
    end
  endtask

  task automatic test_read_id;
    bit to;
    int p0;
    p0 = rd_cnt;
    exp_sdi_q.push_back(8'h40); exp_sdi_q.push_back(8'h03); exp_sdi_q.push_back(8'h00);
    exp_rd_q.push_back(8'h11);
    run_txn(1'b0, 8'h03, 8'h00, to);
    total++;
    if (to) begin bad++; $display("FAIL rdid_timeout got=busy exp=idle"); end
    total++;
    if (rd_cnt - p0 != 1) begin bad++; $display("FAIL rdid_pulses got=%0d exp=1", rd_cnt - p0); end
    total++;
    if (rd_data !== 8'h11) begin bad++; $display("FAIL rdid_hold got=%02h exp=11", rd_data); end
    total++;
    if (exp_sdi_q.size() != 0 || exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL rdid_missing got=%0d exp=0", exp_sdi_q.size() + exp_rd_q.size());
      exp_sdi_q.delete(); exp_rd_q.delete();
    end
  endtask

  task automatic test_stream_read(input logic [7:0] vals [19]);
    bit to;
    int p0;
    p0 = rd_cnt;
    exp_sdi_q.push_back(8'h40); exp_sdi_q.push_back(8'h00);
    for (int i = 0; i < 19; i++) begin
      exp_sdi_q.push_back(8'h00);
      exp_rd_q.push_back(vals[i]);
    end
    csb_low_cnt = 0;
    run_txn(1'b0, 8'h00, 8'd18, to);
    total++;
    if (to) begin bad++; $display("FAIL stream_timeout got=busy exp=idle"); end
    total++;
    if (rd_cnt - p0 != 19) begin bad++; $display("FAIL stream_pulses got=%0d exp=19", rd_cnt - p0); end
    total++;
    if (csb_low_cnt != 2 * 4 + 21 * (1 + 16 * 4)) begin
      bad++;
      $display("FAIL stream_csb_low got=%0d exp=%0d", csb_low_cnt, 2 * 4 + 21 * 65);
    end
    total++;
    if (exp_sdi_q.size() != 0 || exp_rd_q.size() != 0) begin
      bad++;
      $display("FAIL stream_missing got=%0d exp=0", exp_sdi_q.size() + exp_rd_q.size());
      exp_sdi_q.delete(); exp_rd_q.delete();
    end
  endtask

  task automatic test_write_stall;
    int n, d0, stall_bad;
    d0 = done_cnt;
    exp_sdi_q.push_back(8'h80); exp_sdi_q.push_back(8'h0c);
    exp_sdi_q.push_back(8'h3c); exp_sdi_q.push_back(8'ha5);
    @(negedge clock);
    wr_data = 8'h3c; wr_valid = 1'b1;
    rw = 1'b1; addr = 8'h0c; len = 8'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!wr_ready && n < 2000) begin @(negedge clock); n++; end
    @(negedge clock);
    wr_valid = 1'b0; wr_data = 8'ha5;
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_drop got=%b exp=0", wr_ready); end
    n = 0;
    while (!wr_ready && n < 2000) begin @(negedge clock); n++; end
    total++;
    if (n >= 2000) begin bad++; $display("FAIL stall_ready_timeout got=0 exp=1"); end
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0) @(negedge clock);
      if (!(wr_ready === 1'b1 && spi_sck === 1'b0 && spi_csb === 1'b0)) stall_bad++;
    end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL stall_static got=%0d bad cycles exp=0", stall_bad); end
    wr_valid = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL stall_accept got=%b exp=0", wr_ready); end
    n = 0;
    while (busy && n < 2000) begin @(negedge clock); n++; end
    total++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_done got=%0d exp=1", done_cnt - d0);
    end
    total++;
    if (exp_sdi_q.size() != 0) begin
      bad++;
      $display("FAIL stall_missing got=%0d exp=0", exp_sdi_q.size());
      exp_sdi_q.delete();
    end
  endtask

  task automatic test_reset_mid;
    int n, r0, d0, p0;
    bit to;
    r0 = rise_cnt; d0 = done_cnt; p0 = rd_cnt;
    exp_sdi_q.push_back(8'h40);
    @(negedge clock);
    rw = 1'b0; addr = 8'h05; len = 8'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (rise_cnt - r0 < 12 && n < 2000) begin @(negedge clock); n++; end
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (spi_csb !== 1'b1 || spi_sck !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_state got=csb%b sck%b busy%b exp=csb1 sck0 busy0", spi_csb, spi_sck, busy);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (done_cnt != d0 || rd_cnt != p0) begin
      bad++;
      $display("FAIL midrst_pulses got=%0d exp=0", (done_cnt - d0) + (rd_cnt - p0));
    end
    exp_sdi_q.delete();
    exp_sdi_q.push_back(8'h80); exp_sdi_q.push_back(8'h0b); exp_sdi_q.push_back(8'h5a);
    wr_data = 8'h5a; wr_valid = 1'b1;
    run_txn(1'b1, 8'h0b, 8'h00, to);
    wr_valid = 1'b0;
    total++;
    if (to || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL midrst_recover got=%0d exp=1", done_cnt - d0);
    end
    total++;
    if (exp_sdi_q.size() != 0) begin
      bad++;
      $display("FAIL midrst_missing got=%0d exp=0", exp_sdi_q.size());
      exp_sdi_q.delete();
    end
  endtask

  task automatic test_start_held;
    int n, rises, dones, falls, gap_high, r1, r2, pulses, dones2;
    logic prev_sck, prev_csb;
    @(negedge clock);
    rw1 = 1'b0; addr1 = 8'h03; len1 = 8'h00; start1 = 1'b1;
    n = 0;
    while (!busy1 && n < 10) begin @(negedge clock); n++; end
    rises = 0; dones = 0; falls = 0; gap_high = 0; r1 = 0; r2 = 0; pulses = 0;
    prev_sck = sck1; prev_csb = csb1;
    n = 0;
    while (busy1 && n < 500) begin
      if (sck1 && !prev_sck) begin
        rises++;
        if (rises == 1) r1 = cyc;
        if (rises == 2) r2 = cyc;
      end
      if (!csb1 && prev_csb) falls++;
      if (done1) dones++;
      if (rd_valid1) pulses++;
      if (csb1) gap_high++;
      prev_sck = sck1; prev_csb = csb1;
      @(negedge clock);
      n++;
    end
    gap_high += (csb1 === 1'b1) ? 1 : 0;
    total++;
    if (rises != 24) begin bad++; $display("FAIL held_rises got=%0d exp=24", rises); end
    total++;
    if (dones != 1 || falls != 0) begin
      bad++;
      $display("FAIL held_one_txn got=done%0d restart%0d exp=done1 restart0", dones, falls);
    end
    total++;
    if (r2 - r1 != 2) begin bad++; $display("FAIL held_sck_period got=%0d exp=2", r2 - r1); end
    total++;
    if (pulses != 1 || rd_data1 !== 8'h00) begin
      bad++;
      $display("FAIL held_read got=%0d/%02h exp=1/00", pulses, rd_data1);
    end
    @(negedge clock);
    total++;
    if (csb1 !== 1'b0 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL held_second_start got=csb%b busy%b exp=csb0 busy1", csb1, busy1);
    end
    start1 = 1'b0;
    total++;
    if (gap_high != 2) begin bad++; $display("FAIL held_gap got=%0d exp=2", gap_high); end
    dones2 = 0;
    n = 0;
    while (busy1 && n < 500) begin
      if (done1) dones2++;
      @(negedge clock);
      n++;
    end
    total++;
    if (dones2 != 1 || wr_ready1 !== 1'b0 || sdi1 !== 1'b0) begin
      bad++;
      $display("FAIL held_second_done got=%0d exp=1", dones2);
    end
  endtask

  initial begin
    logic [7:0] vals [19];
    vals = '{8'h00, 8'h04, 8'h56, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01,
             8'h00, 8'h00, 8'h00, 8'hff, 8'hef, 8'hff, 8'h03, 8'h12, 8'h04};
    for (int i = 0; i < 256; i++) resp_regs[i] = 8'h00;
    for (int i = 0; i < 19; i++) resp_regs[i] = vals[i];
    resp_addr = 8'h00; mon_shift = 8'h00; spi_sdo = 1'b0;
    start = 1'b0; rw = 1'b0; addr = 8'h00; len = 8'h00; wr_data = 8'h00; wr_valid = 1'b0;
    start1 = 1'b0; rw1 = 1'b0; addr1 = 8'h00; len1 = 8'h00; wr_data1 = 8'h00;
    wr_valid1 = 1'b0; sdo1 = 1'b0;
    test_reset();
    test_write_single();
    test_read_id();
    test_stream_read(vals);
    test_write_stall();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
